// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter slice.
// Holds codebase-wide defaults and a width helper used by the wait counter.
package dmem_arbiter_pkg;

    localparam int DMEM_DATA_W   = 32;
    localparam int DMEM_MAX_WAIT = 15;

    // A counter for MAX_WAIT=0 still needs one bit so the port is legal.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating wait counter: counts cycles a debug request has been held off,
// with synchronous clear and an at-max flag used to force a cycle steal.
module dmem_arb_wait_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int  MAX_WAIT = DMEM_MAX_WAIT,
    localparam int CNT_W    = cnt_width(MAX_WAIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX_CNT) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign at_max = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the dmem port between the core and a debug reader. The core owns the
// port; a debug read is granted at once when the core is halted or debug is
// forced, otherwise after MAX_WAIT cycles by stalling the core for one cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_we,
    input  logic              core_finish,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_force,
    input  logic              dbg_req,
    input  logic [DATA_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_CORE = 2'd0;
    localparam logic [1:0] S_DBG  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       grant;
    logic       at_max;
    logic       cnt_clr;
    logic       cnt_inc;

    assign grant = dbg_req & (core_finish | dbg_force | at_max);

    // The counter only runs while a request waits in the core-owned state.
    assign cnt_inc = (state_q == S_CORE) & dbg_req & ~grant;
    assign cnt_clr = ~cnt_inc;

    dmem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CORE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CORE:  if (grant) state_d = S_DBG;
            S_DBG:   state_d = S_ACK;
            S_ACK:   state_d = S_CORE;
            default: state_d = S_CORE;
        endcase
    end

    always_comb begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_we     = core_we & ~core_finish & ~dbg_force;
        core_stall = dbg_force;
        if (state_q == S_DBG) begin
            mem_addr   = dbg_addr;
            mem_we     = 1'b0;
            core_stall = ~core_finish | dbg_force;
        end
    end

    // Ack is a flop so it is a clean one-cycle pulse aligned with S_ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= (state_q == S_DBG);
            if (state_q == S_DBG) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

    assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural request/age model checked every cycle,
// plus directed scenarios with hand-computed latencies and read data.
module tb_dmem_arbiter;

    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_we;
    logic              core_finish;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              dbg_force;
    logic              dbg_req;
    logic [DATA_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_we     (core_we),
        .core_finish (core_finish),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .dbg_force   (dbg_force),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed dmem stand-in, reloaded while reset is held.
    logic [DATA_W-1:0] mem [0:255];

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 64) ? 32'h0000_00A5 : (32'hD000_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request ages while the core owns the port; it is granted once
    // the core is halted, debug is forced, or the age reaches MAX_WAIT. A grant
    // yields one debug-owned cycle followed by one ack cycle.
    logic              m_dbg;
    logic              m_ack;
    int                m_age;
    logic [DATA_W-1:0] m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dbg   <= 1'b0;
            m_ack   <= 1'b0;
            m_age   <= 0;
            m_rdata <= '0;
        end else if (m_dbg) begin
            m_dbg   <= 1'b0;
            m_ack   <= 1'b1;
            m_rdata <= mem[dbg_addr[9:2]];
        end else if (m_ack) begin
            m_ack <= 1'b0;
        end else if (dbg_req && (core_finish || dbg_force || m_age >= MAX_WAIT)) begin
            m_dbg <= 1'b1;
            m_age <= 0;
        end else if (dbg_req) begin
            m_age <= (m_age < MAX_WAIT) ? m_age + 1 : m_age;
        end else begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] e_addr;
        e_addr = m_dbg ? dbg_addr : core_addr;
        chk("cyc_mem_addr", mem_addr, e_addr);
        chk("cyc_mem_we", 32'(mem_we), 32'(!m_dbg && core_we && !core_finish && !dbg_force));
        if (!m_dbg) chk("cyc_mem_wdata", mem_wdata, core_wdata);
        chk("cyc_stall", 32'(core_stall), 32'((m_dbg && !core_finish) || dbg_force));
        chk("cyc_ack", 32'(dbg_ack), 32'(m_ack));
        chk("cyc_rdata", dbg_rdata, m_rdata);
        chk("cyc_core_rdata", core_rdata, mem[e_addr[9:2]]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_ack(input string name, input int limit, output int n, output int stalls);
        n = 0;
        stalls = 0;
        do begin
            step();
            n++;
            if (core_stall) stalls++;
        end while (!dbg_ack && n < limit);
        if (!dbg_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no ack within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, st, total, acks, stall_at, ack_at, stalls;
        core_addr   = 32'h104;
        core_wdata  = 32'h11;
        core_we     = 1'b1;
        core_finish = 1'b0;
        dbg_force   = 1'b0;
        dbg_req     = 1'b0;
        dbg_addr    = '0;

        // Reset state
        step();
        step();
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h104);
        chk("rst_mem_we", 32'(mem_we), 32'd1);
        rst_n   = 1'b1;
        core_we = 1'b0;
        step();
        chk("post_rst_ack", 32'(dbg_ack), 32'd0);

        // Finished core: immediate grant
        core_finish = 1'b1;
        dbg_req     = 1'b1;
        dbg_addr    = 32'h100;
        run_until_ack("fin", 10, n, st);
        chk("fin_latency", 32'(n), 32'd2);
        chk("fin_stalls", 32'(st), 32'd0);
        chk("fin_rdata", dbg_rdata, 32'h0000_00A5);
        dbg_req = 1'b0;
        step();
        chk("fin_ack_pulse", 32'(dbg_ack), 32'd0);

        // Forced debug: back-to-back reads every 3 cycles
        core_finish = 1'b0;
        dbg_force   = 1'b1;
        core_we     = 1'b1;
        core_addr   = 32'h80;
        dbg_req     = 1'b1;
        total       = 0;
        for (int k = 0; k < 3; k++) begin
            dbg_addr = 32'(k * 4);
            run_until_ack("frc", 10, n, st);
            total += n;
            chk("frc_latency", 32'(total), 32'(2 + 3 * k));
            chk("frc_stalls", 32'(st), 32'(n));
            chk("frc_rdata", dbg_rdata, 32'hD000_0000 | 32'(k));
        end
        dbg_req   = 1'b0;
        dbg_force = 1'b0;
        core_we   = 1'b0;
        step();

        // Running core: steal one cycle after MAX_WAIT, write deferred
        core_addr  = 32'h44;
        core_wdata = 32'h5A5A;
        dbg_addr   = 32'h100;
        dbg_req    = 1'b1;
        stall_at   = -1;
        ack_at     = -1;
        stalls     = 0;
        for (int c = 1; c <= 30 && ack_at < 0; c++) begin
            step();
            if (core_stall) begin
                stalls++;
                if (stall_at < 0) begin
                    stall_at = c;
                    core_we  = 1'b1;
                    #1;
                    chk("run_we_stolen", 32'(mem_we), 32'd0);
                end
            end
            if (dbg_ack) ack_at = c;
        end
        chk("run_stall_at", 32'(stall_at), 32'd16);
        chk("run_stalls", 32'(stalls), 32'd1);
        chk("run_ack_at", 32'(ack_at), 32'd17);
        chk("run_rdata", dbg_rdata, 32'h0000_00A5);
        chk("run_not_written", mem[17], 32'hD000_0011);
        chk("run_we_again", 32'(mem_we), 32'd1);
        dbg_req = 1'b0;
        step();
        chk("run_written", mem[17], 32'h0000_5A5A);
        core_we = 1'b0;

        // Abandoned request restarts the wait from zero
        dbg_addr = 32'h104;
        dbg_req  = 1'b1;
        acks     = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (dbg_ack) acks++;
        end
        dbg_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (dbg_ack) acks++;
        end
        chk("abandon_no_ack", 32'(acks), 32'd0);
        dbg_req = 1'b1;
        run_until_ack("restart", 30, n, st);
        chk("restart_latency", 32'(n), 32'd17);
        chk("restart_stalls", 32'(st), 32'd1);
        chk("restart_rdata", dbg_rdata, 32'hD000_0041);
        dbg_req = 1'b0;
        step();

        // Reset while debug owns the port aborts the read
        core_finish = 1'b1;
        dbg_addr    = 32'h100;
        dbg_req     = 1'b1;
        step();
        chk("abort_dbg_addr", mem_addr, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("abort_ack", 32'(dbg_ack), 32'd0);
        chk("abort_rdata", dbg_rdata, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h44);
        dbg_req = 1'b0;
        step();
        step();
        rst_n       = 1'b1;
        core_finish = 1'b0;
        acks        = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dbg_ack) acks++;
        end
        chk("abort_no_late_ack", 32'(acks), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
